// File: rtl/spi_target.sv
// SPI target (CPHA=0) decoding cmd/addr/[dummy]/data frames onto an 8-bit register-file port.
// Latency: every sclk edge acts 3 clk after it occurs (2-flop sync + edge detect).
// Backpressure: none; the SPI master paces all traffic and the register file must keep up.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   sclk, ssel, mosi    SPI inputs from the master (asynchronous to clk, ssel active low)
//   miso, miso_oe       SPI data out and its buffer enable (miso forced 0 when not enabled)
//   write_enable, write_address, write_data   one-clk write strobe with its address/data
//   read_address, read_data                   registered read address, data returned 1 clk later
//   frame_active        synchronized ssel is asserted
//   access_error        one-clk pulse on an unknown command byte
module spi_target #(
   parameter logic       CPOL         = 1'b1,
   parameter int         DUMMY_CYCLES = 0,
   parameter logic [7:0] CMD_WRITE    = 8'h02,
   parameter logic [7:0] CMD_READ     = 8'h03
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       ssel,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   output logic       write_enable,
   output logic [7:0] write_address,
   output logic [7:0] write_data,
   output logic [7:0] read_address,
   input  logic [7:0] read_data,
   output logic       frame_active,
   output logic       access_error
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] COMMAND    = 3'd1;
   localparam logic [2:0] ADDRESS    = 3'd2;
   localparam logic [2:0] DUMMY      = 3'd3;
   localparam logic [2:0] WRITE_DATA = 3'd4;
   localparam logic [2:0] READ_DATA  = 3'd5;
   localparam logic [2:0] IGNORE     = 3'd6;

   localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

   logic       sclk_s1, sclk_s2, sclk_q;
   logic       ssel_s1, ssel_s2;
   logic       mosi_s1, mosi_s2;
   logic [1:0] sync_ok;
   logic       armed;

   logic [2:0] state;
   logic [2:0] bit_cnt;
   logic [2:0] dummy_cnt;
   logic [6:0] rx_sh;
   logic [6:0] tx_sh;
   logic [7:0] addr;
   logic [7:0] prefetch;
   logic       is_read;
   logic       miso_q;
   logic       ra_chg0, ra_chg1;

   logic       lead_edge, trail_edge;
   logic [7:0] rx_byte;
   logic [2:0] data_state;

   always_comb begin
      lead_edge  = (sclk_q != sclk_s2) && (sclk_s2 == ~CPOL);
      trail_edge = (sclk_q != sclk_s2) && (sclk_s2 == CPOL);
      rx_byte    = {rx_sh, mosi_s2};
      data_state = is_read ? READ_DATA : WRITE_DATA;
   end

   assign frame_active = ~ssel_s2;
   assign miso_oe      = (state == READ_DATA);
   assign miso         = miso_q & miso_oe;

   // Synchronizers. sync_ok marks when ssel_s2 holds a real post-reset sample;
   // armed requires ssel to be seen high before any frame is accepted, so a
   // frame already running when reset releases is not decoded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_s1 <= CPOL;
         sclk_s2 <= CPOL;
         sclk_q  <= CPOL;
         ssel_s1 <= 1'b1;
         ssel_s2 <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         sync_ok <= 2'b00;
         armed   <= 1'b0;
      end else begin
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_q  <= sclk_s2;
         ssel_s1 <= ssel;
         ssel_s2 <= ssel_s1;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
         sync_ok <= {sync_ok[0], 1'b1};
         if (sync_ok[1] && ssel_s2) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         bit_cnt       <= 3'd0;
         dummy_cnt     <= 3'd0;
         rx_sh         <= 7'd0;
         tx_sh         <= 7'd0;
         addr          <= 8'd0;
         prefetch      <= 8'd0;
         is_read       <= 1'b0;
         miso_q        <= 1'b0;
         ra_chg0       <= 1'b0;
         ra_chg1       <= 1'b0;
         write_enable  <= 1'b0;
         write_address <= 8'd0;
         write_data    <= 8'd0;
         read_address  <= 8'd0;
         access_error  <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         access_error <= 1'b0;
         ra_chg0      <= 1'b0;
         ra_chg1      <= ra_chg0;
         // read_data is valid 1 clk after read_address moves; take it then.
         if (ra_chg1) prefetch <= read_data;

         if (state != IDLE && ssel_s2) begin
            // Deselect wins over any sclk edge in the same clk.
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            dummy_cnt <= 3'd0;
            miso_q    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (!ssel_s2 && armed) begin
                     state   <= COMMAND;
                     bit_cnt <= 3'd0;
                     rx_sh   <= 7'd0;
                     is_read <= 1'b0;
                  end
               end
               COMMAND: begin
                  if (lead_edge) begin
                     rx_sh   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (rx_byte == CMD_WRITE) begin
                           is_read <= 1'b0;
                           state   <= ADDRESS;
                        end else if (rx_byte == CMD_READ) begin
                           is_read <= 1'b1;
                           state   <= ADDRESS;
                        end else begin
                           state        <= IGNORE;
                           access_error <= 1'b1;
                        end
                     end
                  end
               end
               ADDRESS: begin
                  if (lead_edge) begin
                     rx_sh   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        addr <= rx_byte;
                        if (is_read) begin
                           read_address <= rx_byte;
                           ra_chg0      <= 1'b1;
                        end
                        state <= (DUMMY_CYCLES > 0) ? DUMMY : data_state;
                     end
                  end
               end
               DUMMY: begin
                  if (lead_edge) begin
                     if (dummy_cnt == DUMMY_LAST) begin
                        dummy_cnt <= 3'd0;
                        bit_cnt   <= 3'd0;
                        state     <= data_state;
                     end else begin
                        dummy_cnt <= dummy_cnt + 3'd1;
                     end
                  end
               end
               WRITE_DATA: begin
                  if (lead_edge) begin
                     rx_sh   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        write_enable  <= 1'b1;
                        write_data    <= rx_byte;
                        write_address <= addr;
                        addr          <= addr + 8'd1;
                     end
                  end
               end
               READ_DATA: begin
                  if (lead_edge) begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end else if (trail_edge) begin
                     // bit_cnt==0 on a trailing edge means a byte boundary:
                     // the end of address/dummy or of the previous data byte.
                     if (bit_cnt == 3'd0) begin
                        tx_sh        <= prefetch[6:0];
                        miso_q       <= prefetch[7];
                        read_address <= read_address + 8'd1;
                        ra_chg0      <= 1'b1;
                     end else begin
                        tx_sh  <= {tx_sh[5:0], 1'b0};
                        miso_q <= tx_sh[6];
                     end
                  end
               end
               IGNORE: begin
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: two instances (CPOL=1/no dummy, CPOL=0/4 dummy bits)
// driven by a bit-level SPI master, checked against a frame-level model.
module tb_spi_target;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] sclk, ssel;
   logic       mosi;
   logic [1:0] miso, miso_oe, we, fa, ae;
   logic [7:0] wa[2], wd[2], ra[2], rd[2];

   always #5 clk = ~clk;

   spi_target #(.CPOL(1'b1), .DUMMY_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .sclk(sclk[0]), .ssel(ssel[0]), .mosi(mosi),
      .miso(miso[0]), .miso_oe(miso_oe[0]), .write_enable(we[0]),
      .write_address(wa[0]), .write_data(wd[0]), .read_address(ra[0]),
      .read_data(rd[0]), .frame_active(fa[0]), .access_error(ae[0]));

   spi_target #(.CPOL(1'b0), .DUMMY_CYCLES(4)) dut1 (
      .clk(clk), .reset(reset), .sclk(sclk[1]), .ssel(ssel[1]), .mosi(mosi),
      .miso(miso[1]), .miso_oe(miso_oe[1]), .write_enable(we[1]),
      .write_address(wa[1]), .write_data(wd[1]), .read_address(ra[1]),
      .read_data(rd[1]), .frame_active(fa[1]), .access_error(ae[1]));

   // Register file stub: registered read, data = address ^ 5A.
   always @(posedge clk) begin
      rd[0] <= ra[0] ^ 8'h5A;
      rd[1] <= ra[1] ^ 8'h5A;
   end

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model state
   logic       bits[$];
   logic       eoe[$];
   logic       ebit[$];
   logic [7:0] dat[$];
   logic [7:0] got[$];
   logic [15:0] wq0[$], wq1[$];
   int         exp_ae[2], ae_cnt[2], stb_cnt[2];
   logic [7:0] exp_ra[2], last_wa[2], last_wd[2];
   logic [15:0] mon_e;

   // Per-cycle compare: gating of miso, every strobe against the model queue.
   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            chk("miso_gated", {31'd0, miso[d] & ~miso_oe[d]}, 32'd0);
            if (we[d]) begin
               stb_cnt[d]++;
               last_wa[d] = wa[d];
               last_wd[d] = wd[d];
               if ((d == 0 && wq0.size() == 0) || (d == 1 && wq1.size() == 0)) begin
                  chk("unexpected_strobe", 32'd1, 32'd0);
               end else begin
                  if (d == 0) mon_e = wq0.pop_front();
                  else        mon_e = wq1.pop_front();
                  chk("strobe_addr", {24'd0, wa[d]}, {24'd0, mon_e[15:8]});
                  chk("strobe_data", {24'd0, wd[d]}, {24'd0, mon_e[7:0]});
               end
            end
            if (ae[d]) ae_cnt[d]++;
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input int d);
      chk("rst_miso", {31'd0, miso[d]}, 32'd0);
      chk("rst_miso_oe", {31'd0, miso_oe[d]}, 32'd0);
      chk("rst_we", {31'd0, we[d]}, 32'd0);
      chk("rst_wa", {24'd0, wa[d]}, 32'd0);
      chk("rst_wd", {24'd0, wd[d]}, 32'd0);
      chk("rst_ra", {24'd0, ra[d]}, 32'd0);
      chk("rst_fa", {31'd0, fa[d]}, 32'd0);
      chk("rst_ae", {31'd0, ae[d]}, 32'd0);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
   endtask

   // Frame model: builds the mosi bit stream and derives expected miso bits,
   // write strobes, error pulses and final read address from the frame rules.
   task automatic build(input int d, input logic [7:0] cmd, input logic [7:0] a, input int cut);
      int dm, n, j;
      logic [7:0] v;
      dm = (d == 0) ? 0 : 4;
      bits.delete(); eoe.delete(); ebit.delete();
      push_byte(cmd);
      push_byte(a);
      for (int i = 0; i < dm; i++) bits.push_back(1'($urandom));
      foreach (dat[b]) push_byte(dat[b]);
      while (bits.size() > cut) void'(bits.pop_back());
      n = bits.size();
      for (int i = 0; i < n; i++) begin
         j = i - 16 - dm;
         v = 8'd0;
         if (j >= 0) v = 8'(a + 8'(j / 8)) ^ 8'h5A;
         eoe.push_back(cmd == 8'h03 && j >= 0);
         ebit.push_back(j >= 0 ? v[7 - (j % 8)] : 1'b0);
      end
      if (cmd == 8'h02) begin
         foreach (dat[b]) begin
            if (16 + dm + 8 * (b + 1) <= n) begin
               if (d == 0) wq0.push_back({8'(a + 8'(b)), dat[b]});
               else        wq1.push_back({8'(a + 8'(b)), dat[b]});
            end
         end
      end
      if (cmd != 8'h02 && cmd != 8'h03 && n >= 8) exp_ae[d]++;
      if (cmd == 8'h03 && n >= 16)
         exp_ra[d] = (n >= 16 + dm) ? 8'(a + 8'd1 + 8'((n - 16 - dm) / 8)) : a;
   endtask

   // SPI master (CPHA=0): drive bit before leading edge, sample miso just before it.
   task automatic run_frame(input int d, input int rst_at);
      int half, k;
      logic cp;
      logic [7:0] acc;
      cp = (d == 0);
      half = $urandom_range(4, 6);
      acc = 8'd0;
      k = 0;
      got.delete();
      ssel[d] = 1'b0;
      mosi = (bits.size() > 0) ? bits[0] : 1'b0;
      wait_clk(half + 3);
      chk("frame_active_on", {31'd0, fa[d]}, 32'd1);
      for (int i = 0; i < bits.size(); i++) begin
         if (i == rst_at) begin
            reset = 1'b0;
            #1;
            chk_zero(0);
            chk_zero(1);
            wait_clk(2);
            reset = 1'b1;
            wait_clk(2);
         end
         chk("miso_oe", {31'd0, miso_oe[d]}, {31'd0, eoe[i]});
         if (eoe[i]) begin
            chk("miso_bit", {31'd0, miso[d]}, {31'd0, ebit[i]});
            acc = {acc[6:0], miso[d]};
            k++;
            if (k == 8) begin
               got.push_back(acc);
               k = 0;
            end
         end
         sclk[d] = ~cp;
         wait_clk(half);
         sclk[d] = cp;
         mosi = (i + 1 < bits.size()) ? bits[i + 1] : 1'b0;
         wait_clk(half);
      end
      wait_clk(4);
      ssel[d] = 1'b1;
      wait_clk(6);
      chk("frame_active_off", {31'd0, fa[d]}, 32'd0);
      chk("strobes_pending", (d == 0) ? wq0.size() : wq1.size(), 32'd0);
      chk("access_error_count", ae_cnt[d], exp_ae[d]);
      chk("read_address", {24'd0, ra[d]}, {24'd0, exp_ra[d]});
   endtask

   initial begin
      int s0, e0;
      reset = 1'b0;
      sclk = 2'b01;
      ssel = 2'b11;
      mosi = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_ae[d] = 0; ae_cnt[d] = 0; stb_cnt[d] = 0;
         exp_ra[d] = 8'd0; last_wa[d] = 8'd0; last_wd[d] = 8'd0;
      end
      wait_clk(3);
      chk_zero(0);
      chk_zero(1);
      reset = 1'b1;
      wait_clk(4);

      // Single write
      s0 = stb_cnt[0];
      dat = '{8'hA5};
      build(0, 8'h02, 8'h10, 1000);
      run_frame(0, -1);
      chk("w1_count", stb_cnt[0] - s0, 32'd1);
      chk("w1_addr", {24'd0, last_wa[0]}, 32'h10);
      chk("w1_data", {24'd0, last_wd[0]}, 32'hA5);

      // Burst write with address wrap
      s0 = stb_cnt[0];
      dat = '{8'h11, 8'h22, 8'h33};
      build(0, 8'h02, 8'hFE, 1000);
      run_frame(0, -1);
      chk("wrap_count", stb_cnt[0] - s0, 32'd3);
      chk("wrap_addr", {24'd0, last_wa[0]}, 32'h00);
      chk("wrap_data", {24'd0, last_wd[0]}, 32'h33);

      // Read burst
      dat = '{8'h00, 8'h00};
      build(0, 8'h03, 8'h20, 1000);
      run_frame(0, -1);
      chk("rd_byte0", {24'd0, got.size() > 0 ? got[0] : 8'hXX}, 32'h7A);
      chk("rd_byte1", {24'd0, got.size() > 1 ? got[1] : 8'hXX}, 32'h7B);

      // Dummy-bit read on the second instance
      dat = '{8'hFF};
      build(1, 8'h03, 8'h00, 1000);
      run_frame(1, -1);
      chk("dummy_rd_byte", {24'd0, got.size() > 0 ? got[0] : 8'hXX}, 32'h5A);

      // Unknown command
      s0 = stb_cnt[0];
      e0 = ae_cnt[0];
      dat = '{8'h77};
      build(0, 8'h9F, 8'h44, 24);
      run_frame(0, -1);
      chk("err_pulses", ae_cnt[0] - e0, 32'd1);
      chk("err_no_strobe", stb_cnt[0] - s0, 32'd0);

      // Abort after 5 bits of a data byte
      s0 = stb_cnt[0];
      dat = '{8'hEE};
      build(0, 8'h02, 8'h40, 21);
      run_frame(0, -1);
      chk("abort_no_strobe", stb_cnt[0] - s0, 32'd0);

      // Reset in the middle of a read frame
      dat = '{8'h00, 8'h00};
      build(0, 8'h03, 8'h30, 1000);
      for (int i = 27; i < eoe.size(); i++) eoe[i] = 1'b0;
      exp_ra[0] = 8'd0;
      exp_ra[1] = 8'd0;
      run_frame(0, 27);

      // Clean frame after reset
      s0 = stb_cnt[0];
      dat = '{8'hC3};
      build(0, 8'h02, 8'h01, 1000);
      run_frame(0, -1);
      chk("post_rst_count", stb_cnt[0] - s0, 32'd1);
      chk("post_rst_addr", {24'd0, last_wa[0]}, 32'h01);
      chk("post_rst_data", {24'd0, last_wd[0]}, 32'hC3);

      // Random frames
      for (int f = 0; f < 40; f++) begin
         int d, nb, full, cut;
         logic [7:0] cmd, a;
         d = $urandom_range(0, 1);
         case ($urandom_range(0, 4))
            0, 1:    cmd = 8'h02;
            2, 3:    cmd = 8'h03;
            default: cmd = 8'($urandom);
         endcase
         a = 8'($urandom);
         nb = $urandom_range(1, 4);
         dat.delete();
         repeat (nb) dat.push_back(8'($urandom));
         full = 16 + ((d == 0) ? 0 : 4) + 8 * nb;
         cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, full) : full;
         build(d, cmd, a, cut);
         run_frame(d, -1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
